// File: rtl/state_seq_pkg.sv
// -----------------------------------------------------------------------------
// state_seq_pkg
// Shared types and helpers for the programmable state sequencer.
//   seq_ctl_e     : control FSM encoding (IDLE / RUN / DRAIN)
//   DEF_DWELL     : dwell loaded into every table entry at reset
//   default_next  : reset successor of entry i in an n-entry ring
// -----------------------------------------------------------------------------
package state_seq_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } seq_ctl_e;

   localparam int DEF_DWELL = 1;

   // Reset chain is a plain ring: 0 -> 1 -> ... -> n-1 -> 0.
   function automatic int default_next(input int i, input int n);
      return (i + 1) % n;
   endfunction

endpackage

// File: rtl/state_seq_table.sv
// -----------------------------------------------------------------------------
// state_seq_table
// Register-file holding the next-state and dwell entry of every sequence state.
// Ports:
//   clk, reset  : clock, asynchronous active-low reset (restores default ring)
//   we          : write strobe; qualified here with busy and index/value range
//   busy        : sequencer running, blocks writes
//   idx         : entry written
//   next_in     : successor written into entry idx
//   dwell_in    : dwell written into entry idx
//   cur         : current state, selects the combinational read
//   cur_next    : successor of cur
//   next_dwell  : dwell of the successor of cur (reload value on exit)
//   home_dwell  : dwell of RESET_STATE (reload value on start / abort)
// -----------------------------------------------------------------------------
module state_seq_table
   import state_seq_pkg::*;
#(
   parameter int NUM_STATES  = 4,
   parameter int STATE_W     = $clog2(NUM_STATES),
   parameter int DWELL_W     = 8,
   parameter int RESET_STATE = 0
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               we,
   input  logic               busy,
   input  logic [STATE_W-1:0] idx,
   input  logic [STATE_W-1:0] next_in,
   input  logic [DWELL_W-1:0] dwell_in,
   input  logic [STATE_W-1:0] cur,
   output logic [STATE_W-1:0] cur_next,
   output logic [DWELL_W-1:0] next_dwell,
   output logic [DWELL_W-1:0] home_dwell
);

   localparam logic [STATE_W:0] LIMIT = (STATE_W + 1)'(NUM_STATES);

   logic [STATE_W-1:0] next_tab  [NUM_STATES];
   logic [DWELL_W-1:0] dwell_tab [NUM_STATES];
   logic               wr_ok;

   // Out-of-range index or successor would let cur_state escape the table,
   // so such writes are silently dropped.
   assign wr_ok = we && !busy
                  && ({1'b0, idx}     < LIMIT)
                  && ({1'b0, next_in} < LIMIT);

   // NOTE: the table is reset on purpose -- the sequencer must run a known
   // ring straight out of reset, so this stays flops rather than a RAM macro.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NUM_STATES; i++) begin
            next_tab[i]  <= STATE_W'(default_next(i, NUM_STATES));
            dwell_tab[i] <= DWELL_W'(DEF_DWELL);
         end
      end else if (wr_ok) begin
         next_tab[idx]  <= next_in;
         dwell_tab[idx] <= dwell_in;
      end
   end

   assign cur_next   = next_tab[cur];
   assign next_dwell = dwell_tab[next_tab[cur]];
   assign home_dwell = dwell_tab[RESET_STATE];

endmodule

// File: rtl/state_seq_prog.sv
// -----------------------------------------------------------------------------
// state_seq_prog
// Programmable state sequencer: walks a run-time next-state table, holding
// each state for its programmed dwell (0 = hold until advance).
// Optional watchdog on advance-wait states: define STATE_SEQ_WDOG_EN.
// Ports:
//   clk, reset  : clock, asynchronous active-low reset
//   cfg_we/idx/next/dwell : table write port (accepted only while idle)
//   start       : begin at RESET_STATE (idle only)
//   abort       : jump to RESET_STATE, keep running, cancel a pending stop
//   stop        : finish the current state, then go idle
//   advance     : exit strobe for dwell-0 states
//   cur_state   : current state index
//   busy        : running (RUN or DRAIN)
//   state_exit  : high on the last cycle of a state
//   cfg_err     : sticky, write attempted while busy; cleared on start
//   wdog_err    : sticky watchdog flag (0 unless STATE_SEQ_WDOG_EN)
// -----------------------------------------------------------------------------
module state_seq_prog
   import state_seq_pkg::*;
#(
   parameter int NUM_STATES  = 4,
   parameter int STATE_W     = $clog2(NUM_STATES),
   parameter int DWELL_W     = 8,
   parameter int RESET_STATE = 0
`ifdef STATE_SEQ_WDOG_EN
   ,
   parameter int WDOG_CYCLES = 1024
`endif
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               cfg_we,
   input  logic [STATE_W-1:0] cfg_idx,
   input  logic [STATE_W-1:0] cfg_next,
   input  logic [DWELL_W-1:0] cfg_dwell,
   input  logic               start,
   input  logic               abort,
   input  logic               stop,
   input  logic               advance,
   output logic [STATE_W-1:0] cur_state,
   output logic               busy,
   output logic               state_exit,
   output logic               cfg_err,
   output logic               wdog_err
);

   localparam logic [STATE_W-1:0] HOME = STATE_W'(RESET_STATE);

   seq_ctl_e           ctl;
   logic [DWELL_W-1:0] cnt;
   logic               stop_pending;
   logic [STATE_W-1:0] cur_next;
   logic [DWELL_W-1:0] next_dwell;
   logic [DWELL_W-1:0] home_dwell;
   logic               waiting;
   logic               wdog_fire;
   logic               start_ok;
   logic               stop_req;

   state_seq_table #(
      .NUM_STATES (NUM_STATES),
      .STATE_W    (STATE_W),
      .DWELL_W    (DWELL_W),
      .RESET_STATE(RESET_STATE)
   ) u_table (
      .clk       (clk),
      .reset     (reset),
      .we        (cfg_we),
      .busy      (busy),
      .idx       (cfg_idx),
      .next_in   (cfg_next),
      .dwell_in  (cfg_dwell),
      .cur       (cur_state),
      .cur_next  (cur_next),
      .next_dwell(next_dwell),
      .home_dwell(home_dwell)
   );

   // A counter of 0 marks a dwell-0 state: it never decrements and only
   // advance (or abort / watchdog) gets it out.
   assign busy     = (ctl != IDLE);
   assign waiting  = busy && (cnt == '0);
   assign start_ok = (ctl == IDLE) && start;
   assign stop_req = (ctl == RUN) && stop && !abort;

   // Combinational so the pulse lines up with the advance strobe itself.
   assign state_exit = busy && !abort && !wdog_fire
                       && ((cnt == DWELL_W'(1)) || (waiting && advance));

   // NOTE: all sequential state below uses non-blocking assignments so every
   // register samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ctl          <= IDLE;
         cur_state    <= HOME;
         cnt          <= '0;
         stop_pending <= 1'b0;
      end else begin
         case (ctl)
            IDLE: begin
               if (start) begin
                  ctl       <= RUN;
                  cur_state <= HOME;
                  cnt       <= home_dwell;
               end
            end
            RUN, DRAIN: begin
               if (abort || wdog_fire) begin
                  cur_state <= HOME;
                  cnt       <= home_dwell;
                  if (abort) begin
                     ctl          <= RUN;
                     stop_pending <= 1'b0;
                  end
               end else if (state_exit) begin
                  cur_state <= cur_next;
                  cnt       <= next_dwell;
                  // A stop landing on the exit cycle already finishes the state.
                  if (stop_pending || stop_req) begin
                     ctl          <= IDLE;
                     stop_pending <= 1'b0;
                  end
               end else begin
                  if (!waiting) cnt <= cnt - 1'b1;
                  if (stop_req) begin
                     ctl          <= DRAIN;
                     stop_pending <= 1'b1;
                  end
               end
            end
            default: ctl <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)               cfg_err <= 1'b0;
      else if (cfg_we && busy)  cfg_err <= 1'b1;
      else if (start_ok)        cfg_err <= 1'b0;
   end

`ifdef STATE_SEQ_WDOG_EN
   localparam int                WDOG_W    = $clog2(WDOG_CYCLES + 1);
   localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYCLES - 1);

   logic [WDOG_W-1:0] wdog_cnt;
   logic              wdog_flag;

   // Fires on the WDOG_CYCLES-th consecutive cycle spent waiting for advance.
   assign wdog_fire = waiting && !advance && !abort && (wdog_cnt == WDOG_LAST);
   assign wdog_err  = wdog_flag;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wdog_cnt  <= '0;
         wdog_flag <= 1'b0;
      end else begin
         if (start_ok)       wdog_flag <= 1'b0;
         else if (wdog_fire) wdog_flag <= 1'b1;
         // Every state entry passes through one of these clear terms.
         if (start_ok || abort || wdog_fire || state_exit || !waiting)
            wdog_cnt <= '0;
         else
            wdog_cnt <= wdog_cnt + 1'b1;
      end
   end
`else
   assign wdog_fire = 1'b0;
   assign wdog_err  = 1'b0;
`endif

endmodule

// File: tb/tb_state_seq_prog.sv
// -----------------------------------------------------------------------------
// tb_state_seq_prog
// Directed bench for state_seq_prog (NUM_STATES=4, DWELL_W=8). Inputs change
// 1 ns after the rising edge; outputs are sampled 1 ns later.
// Define STATE_SEQ_WDOG_EN to include the watchdog scenario (WDOG_CYCLES=16).
// -----------------------------------------------------------------------------
module tb_state_seq_prog;

`ifdef STATE_SEQ_WDOG_EN
   localparam int HOLD = 12;
`else
   localparam int HOLD = 20;
`endif

   logic       clk;
   logic       reset;
   logic       cfg_we;
   logic [1:0] cfg_idx;
   logic [1:0] cfg_next;
   logic [7:0] cfg_dwell;
   logic       start;
   logic       abort;
   logic       stop;
   logic       advance;
   logic [1:0] cur_state;
   logic       busy;
   logic       state_exit;
   logic       cfg_err;
   logic       wdog_err;

   int n_cmp = 0;
   int n_err = 0;

   state_seq_prog #(
      .NUM_STATES (4),
      .DWELL_W    (8),
      .RESET_STATE(0)
`ifdef STATE_SEQ_WDOG_EN
      ,
      .WDOG_CYCLES(16)
`endif
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .cfg_we    (cfg_we),
      .cfg_idx   (cfg_idx),
      .cfg_next  (cfg_next),
      .cfg_dwell (cfg_dwell),
      .start     (start),
      .abort     (abort),
      .stop      (stop),
      .advance   (advance),
      .cur_state (cur_state),
      .busy      (busy),
      .state_exit(state_exit),
      .cfg_err   (cfg_err),
      .wdog_err  (wdog_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input int got, input int exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      tick();
      reset = 1'b1;
      tick();
   endtask

   task automatic write(input logic [1:0] idx, input logic [1:0] nxt, input logic [7:0] dw);
      cfg_we    = 1'b1;
      cfg_idx   = idx;
      cfg_next  = nxt;
      cfg_dwell = dw;
      tick();
      cfg_we    = 1'b0;
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
      #1;
   endtask

   initial begin
      reset = 1'b0; cfg_we = 1'b0; cfg_idx = '0; cfg_next = '0; cfg_dwell = '0;
      start = 1'b0; abort = 1'b0; stop = 1'b0; advance = 1'b0;

      // Reset state
      #12;
      check("rst_cur",   int'(cur_state),  0);
      check("rst_busy",  int'(busy),       0);
      check("rst_exit",  int'(state_exit), 0);
      check("rst_cfg",   int'(cfg_err),    0);
      check("rst_wdog",  int'(wdog_err),   0);
      tick();
      reset = 1'b1;
      tick();

      // Default ring, dwell 1: 0,1,2,3,0 with state_exit every cycle
      do_start();
      for (int i = 0; i < 5; i++) begin
         check("ring_cur",  int'(cur_state),  i % 4);
         check("ring_exit", int'(state_exit), 1);
         check("ring_busy", int'(busy),       1);
         tick();
         #1;
      end

      // Asynchronous reset mid-run: outputs return before any clock edge
      reset = 1'b0;
      #1;
      check("amid_cur",  int'(cur_state),  0);
      check("amid_busy", int'(busy),       0);
      check("amid_exit", int'(state_exit), 0);
      tick();
      reset = 1'b1;
      tick();

      // Reprogrammed chain 0 -> 3 -> 0, state 1 unreachable
      write(2'd1, 2'd2, 8'd3);
      write(2'd3, 2'd0, 8'd1);
      write(2'd0, 2'd3, 8'd1);
      do_start();
      for (int i = 0; i < 6; i++) begin
         check("prog_cur",  int'(cur_state),  (i % 2 == 1) ? 3 : 0);
         check("prog_exit", int'(state_exit), 1);
         tick();
         #1;
      end

      // Dwell 0 on state 2: hold until advance
      do_reset();
      write(2'd2, 2'd3, 8'd0);
      do_start();
      check("adv_s0", int'(cur_state), 0);
      tick(); #1;
      check("adv_s1", int'(cur_state), 1);
      tick(); #1;
      for (int h = 0; h < HOLD; h++) begin
         check("hold_cur",  int'(cur_state),  2);
         check("hold_exit", int'(state_exit), 0);
         tick();
         #1;
      end
      advance = 1'b1;
      #1;
      check("adv_exit", int'(state_exit), 1);
      check("adv_cur",  int'(cur_state),  2);
      tick();
      advance = 1'b0;
      #1;
      check("adv_next", int'(cur_state), 3);
      check("adv_busy", int'(busy),      1);
      check("adv_wdog", int'(wdog_err),  0);

      // Stop mid-dwell of a 5-cycle state 0
      do_reset();
      write(2'd0, 2'd1, 8'd5);
      do_start();
      check("stp_c5", int'(state_exit), 0);
      tick();
      stop = 1'b1;
      #1;
      check("stp_c4", int'(state_exit), 0);
      tick();
      stop = 1'b0;
      #1;
      check("stp_busy_c3", int'(busy),       1);
      check("stp_c3",      int'(state_exit), 0);
      tick(); #1;
      check("stp_c2", int'(state_exit), 0);
      tick(); #1;
      check("stp_exit", int'(state_exit), 1);
      check("stp_cur0", int'(cur_state),  0);
      check("stp_busy", int'(busy),       1);
      tick(); #1;
      check("stp_idle", int'(busy),       0);
      check("stp_cur1", int'(cur_state),  1);
      check("stp_noex", int'(state_exit), 0);

      // Write while busy is dropped and flagged
      do_start();
      cfg_we = 1'b1; cfg_idx = 2'd0; cfg_next = 2'd2; cfg_dwell = 8'd1;
      #1;
      check("cfg_pre", int'(cfg_err), 0);
      tick();
      cfg_we = 1'b0;
      #1;
      check("cfg_set", int'(cfg_err), 1);
      tick(); tick(); tick(); #1;
      check("cfg_dw5_exit", int'(state_exit), 1);
      check("cfg_dw5_cur",  int'(cur_state),  0);
      tick(); #1;
      check("cfg_nxt_keep", int'(cur_state), 1);

      // Start while running is ignored
      start = 1'b1;
      tick();
      start = 1'b0;
      #1;
      check("strun_cur", int'(cur_state), 2);
      check("strun_cfg", int'(cfg_err),   1);

      // Abort + stop together in state 2: abort wins, stop ignored
      abort = 1'b1;
      stop  = 1'b1;
      #1;
      check("abst_noexit", int'(state_exit), 0);
      tick();
      abort = 1'b0;
      stop  = 1'b0;
      #1;
      check("abst_cur",  int'(cur_state),  0);
      check("abst_busy", int'(busy),       1);
      check("abst_exit", int'(state_exit), 0);
      tick(); tick(); tick(); tick(); #1;
      check("abst_dwexit", int'(state_exit), 1);
      tick(); #1;
      check("abst_run_cur",  int'(cur_state), 1);
      check("abst_run_busy", int'(busy),      1);

      // Drain to idle, then start clears cfg_err
      tick(); tick(); tick();
      stop = 1'b1;
      #1;
      check("drn_cur0", int'(cur_state), 0);
      tick();
      stop = 1'b0;
      tick(); tick(); tick(); tick(); #1;
      check("drn_idle", int'(busy),      0);
      check("drn_cur",  int'(cur_state), 1);
      do_start();
      check("clr_cfg",  int'(cfg_err),   0);
      check("clr_cur",  int'(cur_state), 0);

`ifdef STATE_SEQ_WDOG_EN
      // Watchdog: state 1 waits forever, fires after 16 waiting cycles
      do_reset();
      write(2'd1, 2'd2, 8'd0);
      do_start();
      tick(); #1;
      for (int k = 0; k < 16; k++) begin
         check("wd_hold_cur", int'(cur_state), 1);
         check("wd_hold_err", int'(wdog_err),  0);
         tick();
         #1;
      end
      check("wd_err",  int'(wdog_err),  1);
      check("wd_cur",  int'(cur_state), 0);
      check("wd_busy", int'(busy),      1);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/state_seq_prog.md
Name: state_seq_prog

Overview:
- Programmable successor to the fixed 4-state case-based sequencers in the always_ff control blocks.
- Steps through NUM_STATES states along a run-time programmable next-state table.
- Each state has a programmable dwell time. A dwell of 0 means the state waits for an external advance strobe.
- Sits beside datapath controllers; cur_state drives downstream decode.

Parameters:
- NUM_STATES, 4, number of sequence states (2..256).
- STATE_W, $clog2(NUM_STATES), state index width (derived).
- DWELL_W, 8, dwell counter width.
- RESET_STATE, 0, state entered on start and on abort.
- WDOG_CYCLES, 1024, watchdog limit for advance-wait states (used only with the optional feature).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- cfg_we  in  1  table write strobe.
- cfg_idx  in  STATE_W  table entry index.
- cfg_next  in  STATE_W  next state for entry cfg_idx.
- cfg_dwell  in  DWELL_W  dwell cycles for entry cfg_idx; 0 = wait for advance.
- start  in  1  begin sequence from RESET_STATE.
- abort  in  1  force return to RESET_STATE, remain running.
- stop  in  1  finish current state, then go idle.
- advance  in  1  exit strobe for dwell-0 states.
- cur_state  out  STATE_W  current state index.
- busy  out  1  sequencer running.
- state_exit  out  1  one-cycle pulse on the last cycle of a state.
- cfg_err  out  1  sticky: write attempted while busy; cleared on start.
- wdog_err  out  1  sticky watchdog flag.

Behaviour:
- Reset values (asserted low, asynchronous): cur_state=RESET_STATE, busy=0, state_exit=0, cfg_err=0, wdog_err=0, dwell counter=0, stop_pending=0.
- Table reset contents: next[i]=(i+1)%NUM_STATES, dwell[i]=1.
- Control FSM states: IDLE, RUN, DRAIN.
- IDLE:
  - cfg_we updates the table, effective the next cycle.
  - start → RUN; cur_state=RESET_STATE and counter=dwell[RESET_STATE], both the next cycle.
- RUN, dwell>0:
  - Counter decrements each cycle.
  - At counter==1: state_exit=1; next cycle cur_state=next[cur_state] and the counter reloads.
  - Dwell N therefore occupies exactly N cycles.
- RUN, dwell==0:
  - Holds until advance=1. state_exit=1 in that same cycle; transition on the next cycle.
- Case priority in RUN, highest first:
  - abort: cur_state=RESET_STATE next cycle; no state_exit; clears stop_pending.
  - stop: sets stop_pending; FSM → DRAIN.
  - normal stepping.
- DRAIN:
  - Normal stepping continues.
  - On the first state_exit, moves to IDLE; cur_state holds its successor value; busy=0 from that cycle.
  - start in DRAIN is ignored.
- busy=1 in RUN and DRAIN.
- start while RUN is ignored.
- cfg_we while busy: write dropped, cfg_err=1.
- cfg_idx ≥ NUM_STATES: write dropped, no flag.
- Next-state table entries ≥ NUM_STATES cannot exist: writes are dropped.
- Self-loop (next[i]=i) is legal. state_exit still pulses every dwell period.
- Simultaneous abort+stop: abort wins; stop is ignored that cycle.
- Simultaneous advance+abort: abort wins.
- Reset mid-operation: all outputs and the table return to reset values immediately (asynchronous).
- Dwell counter width is DWELL_W. Maximum dwell is 2^DWELL_W−1. No wrap, since it reloads before 0.

Optional Feature:
- Macro: STATE_SEQ_WDOG_EN.
- When defined: a $clog2(WDOG_CYCLES+1)-bit counter runs while in a dwell-0 state without advance.
  - On reaching WDOG_CYCLES: wdog_err=1 (sticky until start); cur_state forced to RESET_STATE next cycle; busy stays 1.
  - The counter clears on every state entry.
- When undefined: no counter; wdog_err tied 0.

Decomposition:
- Package state_seq_pkg:
  - typedef enum {IDLE, RUN, DRAIN} seq_ctl_e.
  - Function default_next(i).
  - Localparam DEF_DWELL=1.
- One sub-module: state_seq_table. Holds the register-file table with write port and qualification, plus a combinational read of next/dwell for cur_state.
- FSM and counters stay in the top level.

Test Plan:
- Reset then start, default table, NUM_STATES=4 → cur_state 0,1,2,3,0 on consecutive cycles; state_exit high every cycle; busy=1.
- Program dwell[1]=3, next[3]=0, next[0]=3, then start → 0 (1 cycle), 3 (1 cycle), 0… ; state 1 never visited.
- dwell[2]=0 with default chain → cur_state holds 2 for 20 cycles until advance; state_exit coincides with advance; state 3 follows.
- stop asserted mid-dwell of dwell[0]=5 → finishes 5 cycles; busy drops the cycle after state_exit; cur_state=1. Then cfg_we while busy → cfg_err=1 and table unchanged.
- abort and stop in the same cycle in state 2 → cur_state=0 next cycle; busy remains 1; no state_exit.
- With STATE_SEQ_WDOG_EN, WDOG_CYCLES=16, dwell[1]=0, no advance → wdog_err=1 after 16 cycles; cur_state=0 the next cycle.
- Reset asserted mid-run → immediate return to reset values.
